dma_mem_responder: RTL and testbench
====================================

DMA_MEM_RESPONDER -- requirements
Module: dma_mem_responder

Interface
REQ-001 Parameter DEPTH, default 256, meaning storage depth in 32-bit words; SHALL be a power of two >= 2.
REQ-002 Parameter RESET_WAIT, default 4'd2, meaning wait_cycles value loaded at reset into the wait-state register.
REQ-003 clk  input  1  clock; all state SHALL change on rising edge.
REQ-004 reset  input  1  reset, asynchronous, active-high.
REQ-005 req_valid  input  1  initiator requests an access this cycle.
REQ-006 req_we  input  1  1 = write, 0 = read.
REQ-007 req_addr  input  32  byte address; bits [1:0] ignored.
REQ-008 req_wdata  input  32  write data.
REQ-009 cfg_wr  input  1  load cfg_wait into the wait-state register.
REQ-010 cfg_wait  input  4  wait-state count per access.
REQ-011 busy  output  1  responder is occupied; requests are ignored while high.
REQ-012 rdata  output  32  read data, valid only while rdata_valid is high.
REQ-013 rdata_valid  output  1  one-cycle completion pulse, reads and writes alike.
REQ-014 err  output  1  one-cycle address error pulse, coincident with rdata_valid.

Function
REQ-015 The FSM SHALL have exactly three states: IDLE, WAIT and RESP.
REQ-016 In IDLE with req_valid=1, the block SHALL latch we, addr and wdata, and load the wait counter from the wait-state register. It SHALL go to WAIT if the count is nonzero, otherwise to RESP.
REQ-017 In WAIT, the counter SHALL decrement each cycle; when counter==1 the next state SHALL be RESP.
REQ-018 On the edge entering RESP, the array SHALL be accessed once: a write commits wdata, and a read loads rdata from the array.
REQ-019 In RESP, rdata_valid SHALL be 1 for exactly one cycle, and the next state SHALL be IDLE unconditionally.
REQ-020 busy SHALL equal (state != IDLE), decoded from the registered state, with no combinational path from req_valid.
REQ-021 Latency: from the accept edge, busy SHALL stay high for W+1 cycles and rdata_valid SHALL rise W+1 cycles later, where W is the latched wait count.
REQ-022 req_valid, and any change on the req_* inputs, SHALL be ignored while busy=1; latched values SHALL be used for the access.
REQ-023 Word index = addr[log2(DEPTH)+1:2]; the address is in range when addr[31:2] < DEPTH.
REQ-024 cfg_wr SHALL update the wait-state register in any state; an access in flight SHALL keep its latched count.
REQ-025 rdata SHALL hold its last value outside rdata_valid; after a write it SHALL be unchanged.

Reset
REQ-026 Asserting reset SHALL force IDLE, busy=0, rdata_valid=0, err=0, rdata=0, counter=0 and wait register=RESET_WAIT.
REQ-027 Reset mid-WAIT SHALL drop the pending write, leaving the array unchanged; array contents SHALL NOT be reset.

Configuration
REQ-028 With macro DMA_MEM_ADDR_ERR_EN defined, an out-of-range access SHALL suppress the write, return rdata=0, and pulse err with rdata_valid.
REQ-029 Without DMA_MEM_ADDR_ERR_EN, the upper address bits SHALL be truncated so the access wraps modulo DEPTH, and err SHALL be tied 0.

Structure
REQ-030 Package dma_mem_pkg SHALL hold the state enum (IDLE/WAIT/RESP), DATA_W=32, WORD_BYTES=4 and WAIT_W=4.
REQ-031 Storage SHALL be sub-module dma_mem_array: single-port, synchronous write, registered read, no reset.

Verification
REQ-032 Write 0xDEADBEEF to 0x10 with wait=2 -> busy high 3 cycles; rdata_valid pulses on cycle 3; word 4 holds 0xDEADBEEF.
REQ-033 Read 0x10 with cfg_wait=0 -> busy high 1 cycle; rdata=0xDEADBEEF with rdata_valid 1 cycle after accept.
REQ-034 Toggle req_addr to 0x20 while busy -> access completes on 0x10; a second req_valid held high is accepted only in the cycle after RESP.
REQ-035 DEPTH=256, write 0x11 to 0x400 -> with DMA_MEM_ADDR_ERR_EN, err=1 and word 0 unchanged; without the macro, word 0 = 0x11 and err=0.
REQ-036 Assert reset in the 2nd WAIT cycle of a write of 0x5 to 0x8 -> busy=0 immediately and word 2 is unchanged; the next read of 0x8 returns the old value.
REQ-037 cfg_wr with cfg_wait=7 during WAIT -> the current access keeps its old count, and the next access shows busy for 8 cycles.

Source files
------------

// File: rtl/dma_mem_pkg.sv
// Shared types and widths for the DMA memory responder.
// The optional address-error feature is enabled by defining DMA_MEM_ADDR_ERR_EN.
package dma_mem_pkg;

  localparam int DATA_W     = 32;
  localparam int WORD_BYTES = 4;
  localparam int WAIT_W     = 4;
  localparam int OFS_W      = $clog2(WORD_BYTES);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_e;

  function automatic int word_index_w(input int depth);
    return $clog2(depth);
  endfunction

endpackage

// File: rtl/dma_mem_array.sv
// Single-port word storage: synchronous write, registered read, contents never reset.
module dma_mem_array
  import dma_mem_pkg::*;
#(
  parameter int DEPTH = 256,
  parameter int AW    = word_index_w(DEPTH)
) (
  input  logic              clk,
  input  logic              en,
  input  logic              we,
  input  logic [AW-1:0]     addr,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (en) begin
      if (we) begin
        mem[addr] <= wdata;
      end else begin
        rdata <= mem[addr];
      end
    end
  end

endmodule

// File: rtl/dma_mem_responder.sv
// Wait-stated memory responder: accept, count down wait states, access the array once, pulse completion.
// Define DMA_MEM_ADDR_ERR_EN to flag out-of-range accesses instead of wrapping modulo DEPTH.
module dma_mem_responder
  import dma_mem_pkg::*;
#(
  parameter int                DEPTH      = 256,
  parameter logic [WAIT_W-1:0] RESET_WAIT = 4'd2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_valid,
  input  logic              req_we,
  input  logic [31:0]       req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  input  logic              cfg_wr,
  input  logic [WAIT_W-1:0] cfg_wait,
  output logic              busy,
  output logic [DATA_W-1:0] rdata,
  output logic              rdata_valid,
  output logic              err
);

  localparam int AW = word_index_w(DEPTH);

  state_e            state_reg, state_next;
  logic [WAIT_W-1:0] wait_reg;
  logic [WAIT_W-1:0] cnt_reg;
  logic              we_reg;
  logic [AW-1:0]     idx_reg;
  logic [DATA_W-1:0] wdata_reg;
  logic [DATA_W-1:0] rdata_reg;

  logic              accept;
  logic              enter_resp;
  logic              acc_we;
  logic [AW-1:0]     acc_idx;
  logic [DATA_W-1:0] acc_wdata;
  logic              mem_en;
  logic [DATA_W-1:0] arr_rdata;
  logic [DATA_W-1:0] resp_rdata;
  logic              unused_addr_bits;

  assign accept     = (state_reg == IDLE) && req_valid;
  // A zero wait count reaches RESP on the accept edge itself, so the array sees the live request.
  assign enter_resp = (accept && (wait_reg == '0)) ||
                      ((state_reg == WAIT) && (cnt_reg == WAIT_W'(1)));
  assign acc_we     = (state_reg == IDLE) ? req_we : we_reg;
  assign acc_idx    = (state_reg == IDLE) ? req_addr[AW+OFS_W-1:OFS_W] : idx_reg;
  assign acc_wdata  = (state_reg == IDLE) ? req_wdata : wdata_reg;

`ifdef DMA_MEM_ADDR_ERR_EN
  localparam logic [31-OFS_W:0] DEPTH_WORDS = (32-OFS_W)'(DEPTH);

  logic oor_reg;
  logic acc_oor;

  assign acc_oor    = (state_reg == IDLE) ? (req_addr[31:OFS_W] >= DEPTH_WORDS) : oor_reg;
  assign mem_en     = enter_resp && !acc_oor;
  assign resp_rdata = oor_reg ? '0 : arr_rdata;
  assign err        = (state_reg == RESP) && oor_reg;
  assign unused_addr_bits = ^req_addr[OFS_W-1:0];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      oor_reg <= 1'b0;
    end else if (accept) begin
      oor_reg <= acc_oor;
    end
  end
`else
  assign mem_en     = enter_resp;
  assign resp_rdata = arr_rdata;
  assign err        = 1'b0;
  assign unused_addr_bits = ^{req_addr[31:AW+OFS_W], req_addr[OFS_W-1:0]};
`endif

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE: if (req_valid) state_next = (wait_reg != '0) ? WAIT : RESP;
      WAIT: if (cnt_reg == WAIT_W'(1)) state_next = RESP;
      RESP: state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg <= IDLE;
      wait_reg  <= RESET_WAIT;
      cnt_reg   <= '0;
      we_reg    <= 1'b0;
      idx_reg   <= '0;
      wdata_reg <= '0;
      rdata_reg <= '0;
    end else begin
      state_reg <= state_next;
      if (cfg_wr) wait_reg <= cfg_wait;
      if (accept) begin
        cnt_reg   <= wait_reg;
        we_reg    <= req_we;
        idx_reg   <= req_addr[AW+OFS_W-1:OFS_W];
        wdata_reg <= req_wdata;
      end else if (state_reg == WAIT) begin
        cnt_reg <= cnt_reg - WAIT_W'(1);
      end
      if ((state_reg == RESP) && !we_reg) rdata_reg <= resp_rdata;
    end
  end

  dma_mem_array #(
    .DEPTH(DEPTH),
    .AW   (AW)
  ) u_array (
    .clk  (clk),
    .en   (mem_en),
    .we   (acc_we),
    .addr (acc_idx),
    .wdata(acc_wdata),
    .rdata(arr_rdata)
  );

  assign busy        = (state_reg != IDLE);
  assign rdata_valid = (state_reg == RESP);
  // Read data is presented straight from the array during RESP and held afterwards.
  assign rdata       = ((state_reg == RESP) && !we_reg) ? resp_rdata : rdata_reg;

endmodule

// File: tb/tb_dma_mem_responder.sv
// Directed self-checking bench for dma_mem_responder; expectations follow DMA_MEM_ADDR_ERR_EN if defined.
module tb_dma_mem_responder;
  import dma_mem_pkg::*;

`ifdef DMA_MEM_ADDR_ERR_EN
  localparam bit ERR_EN = 1'b1;
`else
  localparam bit ERR_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid;
  logic        req_we;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        cfg_wr;
  logic [3:0]  cfg_wait;
  logic        busy;
  logic [31:0] rdata;
  logic        rdata_valid;
  logic        err;

  int n_checks = 0;
  int n_fail   = 0;

  dma_mem_responder #(
    .DEPTH     (256),
    .RESET_WAIT(4'd2)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .req_valid  (req_valid),
    .req_we     (req_we),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .cfg_wr     (cfg_wr),
    .cfg_wait   (cfg_wait),
    .busy       (busy),
    .rdata      (rdata),
    .rdata_valid(rdata_valid),
    .err        (err)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=0x%08h exp=0x%08h", tag, got, exp);
    end
  endtask

  task automatic set_wait(input logic [3:0] v);
    cfg_wr   = 1'b1;
    cfg_wait = v;
    tick();
    cfg_wr   = 1'b0;
  endtask

  // One access; req_* inputs are scrambled while busy to prove the latched copy is used.
  task automatic access(input string tag, input logic we, input logic [31:0] addr,
                        input logic [31:0] wdata, input int exp_busy,
                        input logic [31:0] exp_rdata, input logic exp_err,
                        input bit cfg_mid, input logic [3:0] cfg_val);
    int cyc  = 0;
    int vidx = -1;
    req_valid = 1'b1;
    req_we    = we;
    req_addr  = addr;
    req_wdata = wdata;
    tick();
    req_valid = 1'b0;
    req_we    = ~we;
    req_addr  = addr ^ 32'h30;
    req_wdata = ~wdata;
    while (busy && cyc < 40) begin
      if (cyc == 0 && cfg_mid) begin
        cfg_wr   = 1'b1;
        cfg_wait = cfg_val;
      end else begin
        cfg_wr = 1'b0;
      end
      if (rdata_valid) begin
        vidx = cyc;
        check({tag, "_rdata"}, rdata, exp_rdata);
        check({tag, "_err"}, {31'd0, err}, {31'd0, exp_err});
      end
      cyc++;
      tick();
    end
    cfg_wr = 1'b0;
    check({tag, "_busy_cycles"}, 32'(cyc), 32'(exp_busy));
    check({tag, "_valid_cycle"}, 32'(vidx), 32'(exp_busy - 1));
    check({tag, "_valid_low"}, {31'd0, rdata_valid}, 32'd0);
    check({tag, "_rdata_hold"}, rdata, exp_rdata);
    $display("txn %s we=%0d addr=0x%08h wdata=0x%08h busy_cycles=%0d rdata=0x%08h",
             tag, we, addr, wdata, cyc, rdata);
  endtask

  initial begin
    logic [31:0] after_oor;
    reset = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_addr = '0;
    req_wdata = '0; cfg_wr = 1'b0; cfg_wait = '0;
    tick();
    tick();
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_valid", {31'd0, rdata_valid}, 32'd0);
    check("rst_err", {31'd0, err}, 32'd0);
    check("rst_rdata", rdata, 32'd0);
    reset = 1'b0;
    tick();

    // Reset wait count of 2 gives three busy cycles.
    access("wr_10", 1'b1, 32'h10, 32'hDEADBEEF, 3, 32'h0, 1'b0, 1'b0, 4'd0);
    set_wait(4'd0);
    access("rd_10", 1'b0, 32'h10, 32'h0, 1, 32'hDEADBEEF, 1'b0, 1'b0, 4'd0);
    access("wr_20", 1'b1, 32'h20, 32'hA5A50001, 1, 32'hDEADBEEF, 1'b0, 1'b0, 4'd0);
    access("rd_20", 1'b0, 32'h20, 32'h0, 1, 32'hA5A50001, 1'b0, 1'b0, 4'd0);
    set_wait(4'd3);
    access("rd_10_toggle", 1'b0, 32'h10, 32'h0, 4, 32'hDEADBEEF, 1'b0, 1'b0, 4'd0);

    // req_valid held high: re-accept only in the IDLE cycle after RESP.
    set_wait(4'd1);
    req_valid = 1'b1; req_we = 1'b0; req_addr = 32'h20;
    tick();
    check("held_acc_busy", {31'd0, busy}, 32'd1);
    tick();
    check("held_resp_valid", {31'd0, rdata_valid}, 32'd1);
    check("held_resp_rdata", rdata, 32'hA5A50001);
    tick();
    check("held_gap_busy", {31'd0, busy}, 32'd0);
    tick();
    check("held_reacc_busy", {31'd0, busy}, 32'd1);
    req_valid = 1'b0;
    tick();
    check("held_second_valid", {31'd0, rdata_valid}, 32'd1);
    tick();
    check("held_second_done", {31'd0, busy}, 32'd0);
    $display("txn held_valid addr=0x00000020 rdata=0x%08h", rdata);

    // Out-of-range address 0x400 with DEPTH=256.
    set_wait(4'd0);
    access("wr_0", 1'b1, 32'h0, 32'h77, 1, 32'hA5A50001, 1'b0, 1'b0, 4'd0);
    access("wr_400", 1'b1, 32'h400, 32'h11, 1, 32'hA5A50001, ERR_EN, 1'b0, 4'd0);
    access("rd_0", 1'b0, 32'h0, 32'h0, 1, ERR_EN ? 32'h77 : 32'h11, 1'b0, 1'b0, 4'd0);
    after_oor = ERR_EN ? 32'h0 : 32'h11;
    access("rd_400", 1'b0, 32'h400, 32'h0, 1, after_oor, ERR_EN, 1'b0, 4'd0);

    // Reset during the second WAIT cycle of a write must drop it.
    access("wr_8", 1'b1, 32'h8, 32'hCAFE0002, 1, after_oor, 1'b0, 1'b0, 4'd0);
    set_wait(4'd2);
    req_valid = 1'b1; req_we = 1'b1; req_addr = 32'h8; req_wdata = 32'h5;
    tick();
    req_valid = 1'b0;
    tick();
    check("mid_wait_busy", {31'd0, busy}, 32'd1);
    reset = 1'b1;
    #1;
    check("async_rst_busy", {31'd0, busy}, 32'd0);
    check("async_rst_valid", {31'd0, rdata_valid}, 32'd0);
    check("async_rst_rdata", rdata, 32'd0);
    tick();
    tick();
    reset = 1'b0;
    $display("txn reset_mid_wait addr=0x00000008 busy=%0d", busy);
    access("rd_8_after_rst", 1'b0, 32'h8, 32'h0, 3, 32'hCAFE0002, 1'b0, 1'b0, 4'd0);

    // Wait-state update mid-flight applies only to the next access.
    access("wr_c_cfg7", 1'b1, 32'hC, 32'h3C, 3, 32'hCAFE0002, 1'b0, 1'b1, 4'd7);
    access("rd_c_wait7", 1'b0, 32'hC, 32'h0, 8, 32'h3C, 1'b0, 1'b0, 4'd0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
